multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the PC write/select, IR load, memory request, register-file write and ALU operand selects.
- Sits between the instruction register/decoder and the datapath: PC register, ALU, shared instruction/data memory port and register file.

Parameters:
- RESET_PC, 32'h0000_0000, reported on boot_pc; the PC register loads this value on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  opcode field of the instruction register
- branch_taken  in  1  comparator result for the current B-type (func3 already applied)
- mem_ready  in  1  memory port acknowledges request this cycle
- pc_write  out  1  PC register loads the selected value this cycle
- pc_src  out  1  0 = pc+4, 1 = alu_result
- ir_write  out  1  instruction register loads memory read data
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = store, 0 = read
- reg_write  out  1  register-file write enable
- wb_sel  out  2  00 = alu, 01 = mem data, 10 = pc+4, 11 = imm
- alu_a_sel  out  1  0 = rs1, 1 = pc
- alu_b_sel  out  1  0 = rs2, 1 = imm
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal_instr  out  1  sticky; unsupported opcode decoded
- boot_pc  out  32  constant RESET_PC
- cycle_count  out  32  see Optional Feature
- instret_count  out  32  see Optional Feature

Behaviour:
- States: START, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP (3-bit encoding).
- Outputs are Moore-decoded from the state plus the opcode latched in DECODE. All outputs not listed for a state are 0.
- Reset (async): state = START, illegal_instr = 0, counters = 0. All outputs are 0 while in reset and in START. START lasts exactly one cycle, then goes to FETCH.
- FETCH: mem_req = 1, mem_we = 0. Hold until mem_ready. In the mem_ready cycle, ir_write = 1 and the next state is DECODE. mem_ready sampled in the same cycle as the request is legal (1-cycle fetch).
- DECODE:
  - Latch the opcode.
  - Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode → TRAP, with illegal_instr set on entry.
  - Supported opcodes → EXECUTE.
- EXECUTE, by opcode:
  - R (0110011): a = rs1, b = rs2 → WRITEBACK.
  - I-ALU (0010011): a = rs1, b = imm → WRITEBACK.
  - LOAD/STORE: a = rs1, b = imm → MEMORY.
  - BRANCH: a = pc, b = imm, pc_write = 1, pc_src = branch_taken, instr_done = 1 → FETCH.
  - JAL: a = pc, b = imm → WRITEBACK.
  - JALR: a = rs1, b = imm → WRITEBACK.
  - LUI: → WRITEBACK.
  - AUIPC: a = pc, b = imm → WRITEBACK.
- MEMORY: mem_req = 1; mem_we = 1 for STORE. Hold until mem_ready.
  - STORE on mem_ready: pc_write = 1, pc_src = 0, instr_done = 1 → FETCH.
  - LOAD on mem_ready: → WRITEBACK.
- WRITEBACK: reg_write = 1 and pc_write = 1.
  - wb_sel: LOAD = 01; JAL/JALR = 10; LUI = 11; others = 00.
  - pc_src = 1 for JAL/JALR (the ALU holds the target from EXECUTE); otherwise 0.
  - instr_done = 1 → FETCH.
- Latency, with zero-wait memory: R/I/JAL/JALR/LUI/AUIPC = 4 cycles; BRANCH = 3; STORE = 4; LOAD = 5. Each wait cycle adds 1.
- TRAP: absorbing. All outputs 0 except illegal_instr. Only reset exits.
- mem_req never drops before mem_ready. mem_ready while mem_req = 0 is ignored.
- Reset mid-operation (e.g. mem_req high in MEMORY): mem_req drops asynchronously; no pc_write or reg_write is issued.
- The JALR target LSB clear is the datapath's job, not this block's.

Optional Feature:
- Macro: MULTICYCLE_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle outside reset, including in TRAP.
  - instret_count increments on each instr_done.
  - Both are 32-bit and wrap 0xFFFF_FFFF → 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- Reset released, opcode = 0110011, mem_ready tied 1 → START 1 cycle; ir_write at cycle 1; reg_write + pc_write (pc_src = 0) at cycle 4; instr_done at cycle 4.
- BRANCH 1100011 with branch_taken = 1, then again with 0 → pc_write in EXECUTE with pc_src = 1 then 0; reg_write never asserted; 3 cycles each.
- LOAD with mem_ready delayed 3 cycles in both FETCH and MEMORY → mem_req held steady; wb_sel = 01 in WRITEBACK; total 11 cycles.
- STORE → mem_we = 1 only in MEMORY; pc_write + instr_done on the mem_ready cycle; no WRITEBACK state.
- opcode 7'b1111111 → TRAP after DECODE; illegal_instr = 1 and held; mem_req stays 0 for 20 cycles; rst_n pulse clears it.
- rst_n asserted mid-MEMORY with mem_req = 1 → mem_req low immediately. With the macro defined, counters read 0; after 5 R-type instructions at zero wait, instret_count = 5 and cycle_count = 21.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Define MULTICYCLE_PERF_COUNTERS_EN to build the cycle and retired-instruction counters.
module multicycle_control #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        instr_done,
    output logic        illegal_instr,
    output logic [31:0] boot_pc,
    output logic [31:0] cycle_count,
    output logic [31:0] instret_count
);

    typedef enum logic [2:0] {
        START     = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
        TRAP      = 3'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic        illegal_q, illegal_d;

    function automatic logic is_supported(input logic [6:0] op);
        case (op)
            OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_supported = 1'b1;
            default:                           is_supported = 1'b0;
        endcase
    endfunction

    // Outputs decode from the current state and the latched opcode; only the
    // handshake and branch outcome pass through combinationally.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        illegal_d  = illegal_q;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = 2'b00;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            START: state_d = FETCH;
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                opcode_d = opcode;
                if (is_supported(opcode)) begin
                    state_d = EXECUTE;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXECUTE: begin
                case (opcode_q)
                    OP_R:    state_d = WRITEBACK;
                    OP_IMM, OP_JALR: begin
                        alu_b_sel = 1'b1;
                        state_d   = WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel = 1'b1;
                        state_d   = MEMORY;
                    end
                    OP_BRANCH: begin
                        alu_a_sel  = 1'b1;
                        alu_b_sel  = 1'b1;
                        pc_write   = 1'b1;
                        pc_src     = branch_taken;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end
                    OP_JAL, OP_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        state_d   = WRITEBACK;
                    end
                    OP_LUI:  state_d = WRITEBACK;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMORY: begin
                mem_req = 1'b1;
                mem_we  = (opcode_q == OP_STORE);
                if (mem_ready) begin
                    if (opcode_q == OP_STORE) begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
                case (opcode_q)
                    OP_LOAD:         wb_sel = 2'b01;
                    OP_JAL, OP_JALR: begin
                        wb_sel = 2'b10;
                        pc_src = 1'b1;
                    end
                    OP_LUI:          wb_sel = 2'b11;
                    default:         wb_sel = 2'b00;
                endcase
            end
            TRAP:    state_d = TRAP;
            default: state_d = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= START;
            opcode_q  <= 7'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    assign illegal_instr = illegal_q;
    assign boot_pc       = RESET_PC;

`ifdef MULTICYCLE_PERF_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + 32'd1;
        instret_d = instr_done ? instret_q + 32'd1 : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= 32'd0;
            instret_q <= 32'd0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = 32'd0;
    assign instret_count = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control: one table row per clock cycle.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        pc_write, pc_src, ir_write, mem_req, mem_we, reg_write;
    logic [1:0]  wb_sel;
    logic        alu_a_sel, alu_b_sel, instr_done, illegal_instr;
    logic [31:0] boot_pc, cycle_count, instret_count;

    int errors = 0;
    int checks = 0;

    multicycle_control #(.RESET_PC(32'h0000_1000)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .wb_sel(wb_sel),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .instr_done(instr_done),
        .illegal_instr(illegal_instr), .boot_pc(boot_pc), .cycle_count(cycle_count),
        .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    // Output bundle layout: {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write,
    //                        wb_sel[1:0], alu_a_sel, alu_b_sel, instr_done, illegal_instr}
    localparam logic [11:0] NONE = 12'h000;
    localparam logic [11:0] PW  = 12'h800, PS  = 12'h400, IRW = 12'h200, MR  = 12'h100;
    localparam logic [11:0] MW  = 12'h080, RW  = 12'h040, WB1 = 12'h010, WB2 = 12'h020;
    localparam logic [11:0] WB3 = 12'h030, AA  = 12'h008, AB  = 12'h004, DN  = 12'h002;
    localparam logic [11:0] IL  = 12'h001;

    localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, ST = 7'h23, BR = 7'h63;
    localparam logic [6:0] JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, AUIPC = 7'h17, BAD = 7'h7F;

    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        bt;
        logic        mr;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] op, input logic bt,
                       input logic mr, input logic [11:0] exp);
        vec_t v;
        v.rst_n = r; v.op = op; v.bt = bt; v.mr = mr; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] outs();
        return {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write,
                wb_sel, alu_a_sel, alu_b_sel, instr_done, illegal_instr};
    endfunction

    initial begin
        rst_n = 1'b0; opcode = R; branch_taken = 1'b0; mem_ready = 1'b0;

        add(0, R, 0, 1, NONE);                          // in reset
        add(1, R, 0, 1, NONE);                          // START
        // R-type, zero wait
        add(1, R, 0, 1, MR|IRW); add(1, R, 0, 1, NONE); add(1, R, 0, 1, NONE);
        add(1, R, 0, 1, RW|PW|DN);
        // I-ALU
        add(1, I, 0, 1, MR|IRW); add(1, I, 0, 1, NONE); add(1, I, 0, 1, AB);
        add(1, I, 0, 1, RW|PW|DN);
        // BRANCH taken, then not taken
        add(1, BR, 1, 1, MR|IRW); add(1, BR, 1, 1, NONE); add(1, BR, 1, 1, AA|AB|PW|PS|DN);
        add(1, BR, 0, 1, MR|IRW); add(1, BR, 0, 1, NONE); add(1, BR, 0, 1, AA|AB|PW|DN);
        // JAL; opcode input changes after DECODE, outputs must follow the latched one
        add(1, JAL, 0, 1, MR|IRW); add(1, JAL, 0, 1, NONE); add(1, R, 0, 1, AA|AB);
        add(1, R, 0, 1, RW|PW|PS|WB2|DN);
        // JALR
        add(1, JALR, 0, 1, MR|IRW); add(1, JALR, 0, 1, NONE); add(1, JALR, 0, 1, AB);
        add(1, JALR, 0, 1, RW|PW|PS|WB2|DN);
        // LUI
        add(1, LUI, 0, 1, MR|IRW); add(1, LUI, 0, 1, NONE); add(1, LUI, 0, 1, NONE);
        add(1, LUI, 0, 1, RW|PW|WB3|DN);
        // AUIPC
        add(1, AUIPC, 0, 1, MR|IRW); add(1, AUIPC, 0, 1, NONE); add(1, AUIPC, 0, 1, AA|AB);
        add(1, AUIPC, 0, 1, RW|PW|DN);
        // LOAD with 3 wait cycles in FETCH and MEMORY: 11 cycles
        for (int i = 0; i < 3; i++) add(1, LD, 0, 0, MR);
        add(1, LD, 0, 1, MR|IRW); add(1, LD, 0, 1, NONE); add(1, LD, 0, 1, AB);
        for (int i = 0; i < 3; i++) add(1, LD, 0, 0, MR);
        add(1, LD, 0, 1, MR); add(1, LD, 0, 1, RW|PW|WB1|DN);
        // STORE, zero wait: retires in MEMORY
        add(1, ST, 0, 1, MR|IRW); add(1, ST, 0, 1, NONE); add(1, ST, 0, 1, AB);
        add(1, ST, 0, 1, MR|MW|PW|DN);
        // Reset asserted while a LOAD waits in MEMORY
        add(1, LD, 0, 1, MR|IRW); add(1, LD, 0, 1, NONE); add(1, LD, 0, 1, AB);
        add(1, LD, 0, 0, MR); add(0, LD, 0, 0, NONE); add(1, LD, 0, 1, NONE);
        // Illegal opcode: TRAP, sticky, ignores mem_ready for 20 cycles
        add(1, BAD, 0, 1, MR|IRW); add(1, BAD, 0, 1, NONE);
        for (int i = 0; i < 20; i++) add(1, BAD, 0, 1, IL);
        add(0, R, 0, 1, NONE); add(1, R, 0, 1, NONE); add(1, R, 0, 1, MR|IRW);

        foreach (vecs[k]) begin
            @(negedge clk);
            rst_n = vecs[k].rst_n; opcode = vecs[k].op;
            branch_taken = vecs[k].bt; mem_ready = vecs[k].mr;
            #1;
            check($sformatf("vec%0d", k), {20'd0, outs()}, {20'd0, vecs[k].exp});
        end

        check("boot_pc", boot_pc, 32'h0000_1000);

        // Counter sequence: 5 zero-wait R-type instructions after reset
        @(negedge clk);
        rst_n = 1'b0; opcode = R; mem_ready = 1'b1; branch_taken = 1'b0;
        #1;
        check("cycle_rst", cycle_count, 32'd0);
        check("instret_rst", instret_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (21) @(posedge clk);
        #1;
`ifdef MULTICYCLE_PERF_COUNTERS_EN
        check("cycle_21", cycle_count, 32'd21);
        check("instret_5", instret_count, 32'd5);
`else
        check("cycle_off", cycle_count, 32'd0);
        check("instret_off", instret_count, 32'd0);
`endif
        check("after_5_fetch", {20'd0, outs()}, {20'd0, MR|IRW});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
